bus_master_if: RTL

Per-master bus interface controller that turns a single-cycle access request from a pipeline stage into a complete shared-bus transaction. It raises an active-low request to the round-robin bus arbiter and waits for the grant. It then drives one address strobe, waits for the slave's ready, and returns read data with a completion pulse. One instance sits between each bus master (instruction fetch, data memory stage, DMA) and the arbiter and bus.

---
 rtl/bus_master_if.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/bus_master_if.sv
// bus_master_if
//   Per-master bus interface controller. Converts a single-cycle access
//   request from a pipeline stage into a full shared-bus transaction:
//   arbitration request/grant, one address strobe, wait for slave ready
//   (with timeout), then a one-cycle completion pulse with read data.
//
// Ports
//   clk, reset     clock, synchronous active-high reset
//   req_en         access request (sampled in IDLE only)
//   rw             1 = read, 0 = write
//   addr, wr_data  access address / write data
//   flush          abort a request that has not been granted yet
//   busy           high whenever the controller is not IDLE
//   done, err      one-cycle completion / timeout pulses (err implies done)
//   rd_data        last successfully read data
//   bus_req_       active-low request to arbiter
//   bus_grnt_      active-low grant from arbiter
//   bus_as_        active-low address strobe
//   bus_rw         bus direction, 1 = read
//   bus_addr       bus address
//   bus_wr_data    bus write data
//   bus_rd_data    slave read data
//   bus_rdy_       active-low slave ready

module bus_master_if #(
    parameter int unsigned ADDR_W  = 30,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_en,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rd_data,
    output logic              bus_req_,
    input  logic              bus_grnt_,
    output logic              bus_as_,
    output logic              bus_rw,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wr_data,
    input  logic [DATA_W-1:0] bus_rd_data,
    input  logic              bus_rdy_
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_ACCESS,
        ST_WAIT
    } state_t;

    // TIMEOUT is limited to 2..255, so an 8-bit counter always suffices.
    localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [7:0]          r_cnt;
    logic [7:0]          w_cnt_nxt;
    logic                w_req_nxt;
    logic                w_as_nxt;
    logic                w_rw_nxt;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [DATA_W-1:0]   w_wd_nxt;
    logic [DATA_W-1:0]   w_rd_nxt;
    logic                w_done_nxt;
    logic                w_err_nxt;

    assign busy = (r_state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            bus_req_    <= 1'b1;
            bus_as_     <= 1'b1;
            bus_rw      <= 1'b1;
            bus_addr    <= '0;
            bus_wr_data <= '0;
            rd_data     <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            bus_req_    <= w_req_nxt;
            bus_as_     <= w_as_nxt;
            bus_rw      <= w_rw_nxt;
            bus_addr    <= w_addr_nxt;
            bus_wr_data <= w_wd_nxt;
            rd_data     <= w_rd_nxt;
            done        <= w_done_nxt;
            err         <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_req_nxt   = bus_req_;
        w_as_nxt    = bus_as_;
        w_rw_nxt    = bus_rw;
        w_addr_nxt  = bus_addr;
        w_wd_nxt    = bus_wr_data;
        w_rd_nxt    = rd_data;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (req_en && !flush) begin
                    w_addr_nxt  = addr;
                    w_rw_nxt    = rw;
                    w_wd_nxt    = wr_data;
                    w_req_nxt   = 1'b0;
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (flush) begin
                    w_req_nxt   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (!bus_grnt_) begin
                    w_as_nxt    = 1'b0;
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                w_as_nxt    = 1'b1;
                w_cnt_nxt   = '0;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // Ready is tested before the timeout so a ready arriving in
                // the final WAIT cycle completes normally without err.
                if (!bus_rdy_) begin
                    w_done_nxt  = 1'b1;
                    if (bus_rw) begin
                        w_rd_nxt = bus_rd_data;
                    end
                    w_req_nxt   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == LP_CNT_LAST) begin
                    w_done_nxt  = 1'b1;
                    w_err_nxt   = 1'b1;
                    w_req_nxt   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
